universal_shift_reg: RTL and testbench



---
 rtl/universal_shift_reg_pkg.sv | 19 +
 rtl/universal_shift_reg_shift_bit_counter.sv | 68 ++++++
 rtl/universal_shift_reg.sv | 101 ++++++++++
 tb/tb_universal_shift_reg.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/universal_shift_reg_pkg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_pkg
// Shared definitions for the universal shift register:
//   - the operation-select encodings on the 2-bit mode port
//   - cnt_width(): the bit-counter width for a given register length
// -----------------------------------------------------------------------------
package universal_shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Width of a counter that indexes shifts 0..width-1 within one word.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/universal_shift_reg_shift_bit_counter.sv
// -----------------------------------------------------------------------------
// shift_bit_counter
// Counts shifts within a WIDTH-bit word and pulses word_done for one cycle
// after the edge that performs the WIDTH-th shift (the same edge that wraps
// the count back to 0).
// Ports:
//   clk       in   clock, rising-edge
//   rst       in   synchronous reset, active-low
//   clear     in   restart the word (parallel load); discards a partial count
//   inc       in   one shift happened this cycle
//   bit_cnt   out  shifts since the last clear, reset or wrap
//   word_done out  one-cycle pulse after a completed word
// -----------------------------------------------------------------------------
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] bit_cnt,
    output logic          word_done
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          done_r;
    logic          done_s;

    // Next count and completion flag; clear has priority over inc.
    always_comb begin
        cnt_s  = cnt_r;
        done_s = 1'b0;
        if (clear) begin
            cnt_s  = {CW{1'b0}};
            done_s = 1'b0;
        end else if (inc) begin
            if (cnt_r == CNT_MAX) begin
                cnt_s  = {CW{1'b0}};
                done_s = 1'b1;
            end else begin
                cnt_s  = cnt_r + CW'(1);
                done_s = 1'b0;
            end
        end else begin
            cnt_s  = cnt_r;
            done_s = 1'b0;
        end
    end

    // Counter and pulse registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= {CW{1'b0}};
            done_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            done_r <= done_s;
        end
    end

    assign bit_cnt   = cnt_r;
    assign word_done = done_r;

endmodule

// File: rtl/universal_shift_reg.sv
// -----------------------------------------------------------------------------
// universal_shift_reg
// Parametrised universal shift register usable as PISO, SIPO or SISO.
// Ports:
//   clk          in   clock, rising-edge
//   rst          in   synchronous reset, active-low; overrides en and mode
//   en           in   clock enable; 0 holds all state
//   mode         in   00 HOLD, 01 SHR, 10 SHL, 11 LOAD
//   ser_in_r     in   serial bit entering the MSB on SHR
//   ser_in_l     in   serial bit entering the LSB on SHL
//   par_in       in   parallel load data
//   q            out  register contents
//   ser_out_lsb  out  q[0], next bit out on SHR
//   ser_out_msb  out  q[WIDTH-1], next bit out on SHL
//   bit_cnt      out  shifts since the last LOAD, reset or wrap
//   word_done    out  one-cycle pulse after the WIDTH-th shift of a word
// -----------------------------------------------------------------------------
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [1:0]                  mode,
    input  logic                        ser_in_r,
    input  logic                        ser_in_l,
    input  logic [WIDTH-1:0]            par_in,
    output logic [WIDTH-1:0]            q,
    output logic                        ser_out_lsb,
    output logic                        ser_out_msb,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt,
    output logic                        word_done
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_s;
    logic             shift_s;
    logic             load_s;

    // Datapath next-state: one case on mode, gated by the clock enable.
    always_comb begin
        q_s     = q_r;
        shift_s = 1'b0;
        load_s  = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD: begin
                    q_s = q_r;
                end
                MODE_SHR: begin
                    q_s     = {ser_in_r, q_r[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_SHL: begin
                    q_s     = {q_r[WIDTH-2:0], ser_in_l};
                    shift_s = 1'b1;
                end
                MODE_LOAD: begin
                    q_s    = par_in;
                    load_s = 1'b1;
                end
                default: begin
                    q_s = q_r;
                end
            endcase
        end else begin
            q_s = q_r;
        end
    end

    // Shift register storage with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_r <= RESET_VALUE;
        end else begin
            q_r <= q_s;
        end
    end

    shift_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_s),
        .inc       (shift_s),
        .bit_cnt   (bit_cnt),
        .word_done (word_done)
    );

    assign q           = q_r;
    assign ser_out_lsb = q_r[0];
    assign ser_out_msb = q_r[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic         ser_in_r;
    logic         ser_in_l;
    logic [W-1:0] par_in;
    logic [W-1:0] q;
    logic         ser_out_lsb;
    logic         ser_out_msb;
    logic [2:0]   bit_cnt;
    logic         word_done;

    universal_shift_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .ser_in_r    (ser_in_r),
        .ser_in_l    (ser_in_l),
        .par_in      (par_in),
        .q           (q),
        .ser_out_lsb (ser_out_lsb),
        .ser_out_msb (ser_out_msb),
        .bit_cnt     (bit_cnt),
        .word_done   (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tgt;
        int unsigned q;
        int          cnt;
        bit          done;
    } exp_t;

    exp_t        sb[$];
    int          edge_cnt = 0;
    int          total    = 0;
    int          passed   = 0;
    int          wd_seen  = 0;

    // reference model state (plain integers)
    int unsigned m_q    = 0;
    int          m_cnt  = 0;
    bit          m_done = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s at edge %0d: actual=%0h required=%0h", name, edge_cnt, act, exp);
    endtask

    // monitor: pops every expectation whose edge has happened
    always @(negedge clk) begin : mon
        exp_t e;
        while (sb.size() > 0 && sb[0].tgt <= edge_cnt) begin
            e = sb.pop_front();
            if (word_done === 1'b1) wd_seen++;
            chk("q", (q === 8'bx) ? -1 : longint'(q), longint'(e.q));
            chk("ser_out_lsb", longint'(ser_out_lsb), longint'(e.q & 1));
            chk("ser_out_msb", longint'(ser_out_msb), longint'((e.q >> 7) & 1));
            chk("bit_cnt", longint'(bit_cnt), longint'(e.cnt));
            chk("word_done", longint'(word_done), longint'(e.done));
        end
    end

    task automatic count_shift();
        m_cnt++;
        if (m_cnt == W) begin
            m_cnt  = 0;
            m_done = 1;
        end else begin
            m_done = 0;
        end
    endtask

    task automatic step(input bit r, input bit e, input logic [1:0] m,
                        input bit sr, input bit sl, input logic [7:0] p);
        exp_t x;
        rst = r; en = e; mode = m; ser_in_r = sr; ser_in_l = sl; par_in = p;
        if (!r) begin
            m_q = 0; m_cnt = 0; m_done = 0;
        end else if (!e || m == 2'd0) begin
            m_done = 0;
        end else if (m == 2'd1) begin
            m_q = (m_q / 2) + (sr ? 128 : 0);
            count_shift();
        end else if (m == 2'd2) begin
            m_q = ((m_q * 2) + (sl ? 1 : 0)) % 256;
            count_shift();
        end else begin
            m_q = p; m_cnt = 0; m_done = 0;
        end
        x.tgt = edge_cnt + 1; x.q = m_q; x.cnt = m_cnt; x.done = m_done;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic shr(input bit sr);  step(1'b1, 1'b1, 2'd1, sr, 1'($urandom), 8'($urandom)); endtask
    task automatic shl(input bit sl);  step(1'b1, 1'b1, 2'd2, 1'($urandom), sl, 8'($urandom)); endtask
    task automatic load(input logic [7:0] p); step(1'b1, 1'b1, 2'd3, 1'($urandom), 1'($urandom), p); endtask
    task automatic hold();             step(1'b1, 1'b1, 2'd0, 1'($urandom), 1'($urandom), 8'($urandom)); endtask

    initial begin
        int wd0;
        rst = 1'b0; en = 1'b0; mode = 2'd0; ser_in_r = 1'b0; ser_in_l = 1'b0; par_in = 8'h00;

        // reset priority over LOAD
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);

        // PISO right
        load(8'hA5);
        for (int i = 0; i < 8; i++) shr(1'b0);
        hold(); hold();

        // SHL / SIPO
        load(8'h81);
        for (int i = 0; i < 3; i++) shl(1'b1);

        // enable and HOLD gaps
        load(8'($urandom));
        for (int i = 0; i < 4; i++) shr(1'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        hold(); hold();
        for (int i = 0; i < 4; i++) shr(1'($urandom));
        hold(); hold();

        // LOAD mid-word
        load(8'($urandom));
        for (int i = 0; i < 5; i++) shr(1'($urandom));
        load(8'h3C);
        for (int i = 0; i < 8; i++) shr(1'($urandom));
        hold();

        // continuous stream: three back-to-back words
        load(8'h00);
        @(negedge clk); #1;
        wd0 = wd_seen;
        for (int i = 0; i < 24; i++) shr((i % 2) == 0);
        hold();
        @(negedge clk); #1;
        chk("stream_word_done_count", longint'(wd_seen - wd0), 64'd3);

        // reset mid-word
        for (int i = 0; i < 6; i++) shr(1'($urandom));
        step(1'b0, 1'b1, 2'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        hold();

        // random soak
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) != 0), 2'($urandom),
                 1'($urandom), 1'($urandom), 8'($urandom));

        @(negedge clk); #1;
        chk("scoreboard_drained", longint'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
